ps2_rx_frame: RTL and testbench

- Upstream stage of the keyboard path: receives raw PS/2 clock/data lines from the keyboard and deframes 11-bit frames.
- Each 8-bit scan byte is delivered as a one-cycle strobe plus data.
- The break-code/key-code stage consumes these outputs directly: rx_done_tick drives its scan_done_tick, and dout drives its scan_out.
- Also handles input synchronisation, clock-line glitch filtering, parity/stop checking and a stuck-frame watchdog.

---
 rtl/ps2_rx_frame.sv | 129 ++++++++++++
 tb/tb_ps2_rx_frame.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_frame.sv
// PS/2 receive deframer: synchronises and glitch-filters the keyboard lines and
// extracts 8-bit scan bytes from 11-bit frames, with parity/stop checks and a watchdog.
module ps2_rx_frame #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000,
  parameter int TO_W        = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       err_tick,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DPS, LOAD} state_t;

  state_t                state_q, state_d;
  logic [1:0]            c_sync_q, d_sync_q;
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  f_q, f_d;
  logic                  fall, d_s;
  logic [3:0]            cnt_q, cnt_d;
  logic [9:0]            b_q, b_d, b_shift;
  logic [TO_W-1:0]       wd_q, wd_d;
  logic [7:0]            dout_q, dout_d;
  logic                  done_q, done_d, err_q, err_d;

  // Frame layout is {stop, parity, d7..d0}; a good frame has stop=1 and odd parity.
  function automatic logic frame_ok(input logic [9:0] f);
    return f[9] & (^f[8:0]);
  endfunction

  assign d_s     = d_sync_q[1];
  assign filt_d  = {c_sync_q[1], filt_q[FILTER_LEN-1:1]};
  assign f_d     = (filt_q == '0) ? 1'b0 : ((filt_q == '1) ? 1'b1 : f_q);
  assign fall    = f_q & ~f_d;
  assign b_shift = {d_s, b_q[9:1]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      c_sync_q <= '1;
      d_sync_q <= '1;
      filt_q   <= '1;
      f_q      <= 1'b1;
      cnt_q    <= '0;
      b_q      <= '0;
      wd_q     <= '0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_sync_q <= {c_sync_q[0], ps2c};
      d_sync_q <= {d_sync_q[0], ps2d};
      filt_q   <= filt_d;
      f_q      <= f_d;
      cnt_q    <= cnt_d;
      b_q      <= b_d;
      wd_q     <= wd_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // The stop-bit fall resolves the frame directly, so the registered ticks
  // land in the single LOAD cycle that follows it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    wd_d    = wd_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall && rx_en && !d_s) begin
          b_d     = '0;
          cnt_d   = 4'd9;
          wd_d    = '0;
          state_d = DPS;
        end
      end
      DPS: begin
        if (fall) begin
          b_d  = b_shift;
          wd_d = '0;
          if (cnt_q == 4'd0) begin
            state_d = LOAD;
            if (frame_ok(b_shift)) begin
              dout_d = b_shift[7:0];
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end else if (wd_q == TO_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          wd_d    = '0;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      LOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy         = (state_q != IDLE);
    rx_done_tick = done_q;
    err_tick     = err_q;
    dout         = dout_q;
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: stimulus pushes expected ticks, a monitor
// pops and compares kind, dout and arrival cycle whenever a tick appears.
module tb_ps2_rx_frame;

  localparam int FL   = 8;
  localparam int TO   = 1000;
  localparam int TOW  = 10;
  localparam int K_GOOD = 0;
  localparam int K_ERR  = 1;
  localparam int K_NONE = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       rx_en = 1'b1;
  logic       rx_done_tick, err_tick, busy;
  logic [7:0] dout;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t       sbq[$];
  exp_t       e_mon;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         last_low = 0;
  logic [7:0] model_dout = 8'h00;
  logic       prev_done = 1'b0;
  logic       prev_err  = 1'b0;

  ps2_rx_frame #(
    .FILTER_LEN (FL),
    .TIMEOUT_CYC(TO),
    .TO_W       (TOW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2c        (ps2c),
    .ps2d        (ps2d),
    .rx_en       (rx_en),
    .rx_done_tick(rx_done_tick),
    .dout        (dout),
    .err_tick    (err_tick),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every tick must match the oldest expected event.
  always begin
    @(posedge clk);
    #1;
    if (rx_done_tick || err_tick) begin
      check("tick_exclusive", 32'(rx_done_tick & err_tick), 32'd0);
      check("tick_width", 32'((rx_done_tick & prev_done) | (err_tick & prev_err)), 32'd0);
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_tick: done=%0b err=%0b dout=%0h, none expected (cycle %0d)",
                 rx_done_tick, err_tick, dout, cyc);
      end else begin
        e_mon = sbq.pop_front();
        check("tick_kind_err", 32'(err_tick), 32'(e_mon.is_err));
        check("tick_dout", 32'(dout), 32'(e_mon.data));
        check("tick_cycle", 32'(cyc), 32'(e_mon.at));
      end
    end
    prev_done = rx_done_tick;
    prev_err  = err_tick;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b, input bit glitch);
    ps2d = b;
    wait_cyc(25);
    ps2c = 1'b0;
    last_low = cyc;
    wait_cyc(50);
    ps2c = 1'b1;
    if (glitch) begin
      wait_cyc(15);
      ps2c = 1'b0;
      wait_cyc(3);
      ps2c = 1'b1;
      wait_cyc(7);
    end else begin
      wait_cyc(25);
    end
  endtask

  task automatic push_exp(input bit is_err, input logic [7:0] data, input int at);
    exp_t t;
    t.is_err = is_err;
    t.data   = data;
    t.at     = at;
    sbq.push_back(t);
  endtask

  // Stop bit is sent inline so the expected event is queued at its falling edge.
  task automatic send_frame(input logic [7:0] data, input bit par, input bit glitch, input int kind);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(data[i], glitch);
    send_bit(par, glitch);
    ps2d = 1'b1;
    wait_cyc(25);
    ps2c = 1'b0;
    if (kind == K_GOOD) model_dout = data;
    if (kind != K_NONE) push_exp(kind == K_ERR, model_dout, cyc + FL + 3);
    wait_cyc(50);
    ps2c = 1'b1;
    wait_cyc(25);
  endtask

  initial begin
    wait_cyc(3);
    check("reset_dout", 32'(dout), 32'h00);
    check("reset_done", 32'(rx_done_tick), 32'd0);
    check("reset_err", 32'(err_tick), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    wait_cyc(5);

    // Parity error on 0x1C: err only, dout keeps reset value
    send_frame(8'h1C, 1'b1, 1'b0, K_ERR);
    wait_cyc(10);
    check("parerr_dout", 32'(dout), 32'h00);
    check("parerr_busy", 32'(busy), 32'd0);

    send_frame(8'h1C, 1'b0, 1'b0, K_GOOD);
    wait_cyc(10);
    check("1c_dout", 32'(dout), 32'h1C);
    check("1c_busy", 32'(busy), 32'd0);

    send_frame(8'hF0, 1'b1, 1'b0, K_GOOD);
    send_frame(8'h1C, 1'b0, 1'b0, K_GOOD);
    wait_cyc(10);
    check("f0_1c_dout", 32'(dout), 32'h1C);

    send_frame(8'h5A, 1'b1, 1'b1, K_GOOD);
    wait_cyc(10);
    check("glitch_dout", 32'(dout), 32'h5A);

    // Truncated frame: start + 4 data bits of 0x29, then silence
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    push_exp(1'b1, model_dout, last_low + FL + 3 + TO);
    check("trunc_busy_mid", 32'(busy), 32'd1);
    wait_cyc(TO + 50);
    check("trunc_busy_after", 32'(busy), 32'd0);
    check("trunc_dout", 32'(dout), 32'h5A);
    send_frame(8'h29, 1'b0, 1'b0, K_GOOD);
    wait_cyc(10);
    check("29_dout", 32'(dout), 32'h29);

    rx_en = 1'b0;
    send_frame(8'h66, 1'b1, 1'b0, K_NONE);
    wait_cyc(10);
    check("rxen_off_busy", 32'(busy), 32'd0);
    check("rxen_off_dout", 32'(dout), 32'h29);
    rx_en = 1'b1;

    // Reset in the middle of a frame
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check("midrst_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    wait_cyc(1);
    reset = 1'b1;
    model_dout = 8'h00;
    check("midrst_dout", 32'(dout), 32'h00);
    check("midrst_done", 32'(rx_done_tick), 32'd0);
    check("midrst_err", 32'(err_tick), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    wait_cyc(200);
    send_frame(8'h66, 1'b1, 1'b0, K_GOOD);
    wait_cyc(50);
    check("66_dout", 32'(dout), 32'h66);
    check("pending_events", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
